game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Top-level game sequencer for the credits/lives subsystem. It debounces the coin and start buttons, owns the credit and life counters, and runs the attract → ready → playing → dying → game-over state machine. The credit-coin and life-icon bitmap blocks only display the counts it exports, and the gameplay objects are gated by its status outputs. It is the single writer of credits and lives in the design.

## Interface
Parameters:
- MAX_CREDITS, 5, credit counter saturation value.
- START_LIVES, 3, lives loaded at game start.
- MAX_LIVES, 5, lives saturation value for bonus life.
- DEBOUNCE_FRAMES, 3, consecutive low frame samples needed to accept a press.
- DEATH_FRAMES, 60, freeze duration after a hit, in frames.
- GAMEOVER_FRAMES, 180, game-over display duration, in frames.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- coinN  in  1  coin key, active-low, raw.
- startN  in  1  start key, active-low, raw.
- playerHit  in  1  one-cycle pulse, player destroyed.
- levelCleared  in  1  one-cycle pulse, wave destroyed.
- credits  out  4  current credit count, 0..MAX_CREDITS.
- lives  out  3  current lives, 0..MAX_LIVES.
- gameState  out  3  encoded FSM state.
- gameActive  out  1  high in PLAYING only.
- freezeN  out  1  low in DYING and GAME_OVER; gameplay objects hold position.
- newGame  out  1  one-cycle pulse at game start; gameplay blocks reinitialise on it.
- gameOver  out  1  one-cycle pulse on entry to GAME_OVER.

## Operation
Debounce (per button):
- Sampled only on startOfFrame.
- A low sample increments the low-count, saturating at DEBOUNCE_FRAMES. A high sample clears the low-count and re-arms.
- When the low-count reaches DEBOUNCE_FRAMES while armed, the debouncer emits a one-cycle press pulse and disarms.
- Result: exactly one press per physical hold.

Credits:
- The counter updates every cycle by this rule: consume = startPress accepted in READY; tmp = credits − consume; add = coinPress && tmp < MAX_CREDITS; credits_next = tmp + add.
- A coin press at MAX_CREDITS with no consume is discarded.
- Coin presses are accepted in every state.

FSM states and transitions:
- IDLE → READY when credits > 0.
- READY, on startPress:
  - credit consumed, lives ← START_LIVES, newGame pulses, → PLAYING.
  - startPress in any other state is ignored.
- PLAYING, on playerHit:
  - lives − 1.
  - If the result is 0: → GAME_OVER, gameOver pulses.
  - Otherwise: → DYING, frame counter cleared.
- PLAYING, on levelCleared:
  - lives + 1, saturating at MAX_LIVES.
  - If playerHit and levelCleared arrive in the same cycle, playerHit wins and levelCleared is dropped.
- DYING → PLAYING after DEATH_FRAMES startOfFrame pulses. playerHit and levelCleared are ignored in DYING.
- GAME_OVER, after GAMEOVER_FRAMES startOfFrame pulses:
  - → READY if credits > 0, else → IDLE.
  - lives stay 0.
- gameState encoding: IDLE = 0, READY = 1, PLAYING = 2, DYING = 3, GAME_OVER = 4.

## Timing
- Reset values: state IDLE, credits 0, lives 0, gameActive 0, freezeN 1, newGame 0, gameOver 0, frame counter 0, debouncers armed with low-count 0.
- Reset asserted mid-game returns everything to these values immediately (asynchronous).
- All outputs are registered. credits and lives change on the clk edge after the causing pulse.
- Press-to-effect latency: the press pulse appears 1 cycle after the qualifying startOfFrame; counters and state update 1 cycle after that.
- IDLE→READY takes 1 cycle after credits becomes nonzero.
- Frame counters: DYING lasts exactly DEATH_FRAMES frame pulses, counted from the first startOfFrame after entry. The exit transition happens on the clk edge following the final pulse.
- The frame counter is wide enough for the larger of DEATH_FRAMES and GAMEOVER_FRAMES, and is cleared on every state entry.

## Configuration
- FREE_PLAY_EN defined:
  - READY is entered from IDLE regardless of credits.
  - startPress does not consume a credit.
  - GAME_OVER always exits to READY.
  - Coin handling is unchanged.
- FREE_PLAY_EN undefined: behaviour exactly as in Operation.

## Structure
- Package game_ctrl_pkg holds:
  - the game_state_t enum with the encodings above;
  - default constants for MAX_CREDITS, START_LIVES and MAX_LIVES;
  - the width localparams for credits (4) and lives (3).
- Sub-module frame_debouncer (raw input, startOfFrame → press pulse) is instantiated twice, once for coin and once for start.

## Test plan
- Coin held low 3 frames, then released → credits 0→1 exactly once; IDLE→READY. Coin held 10 frames → still +1 only.
- Six separate coin presses → credits saturate at 5. Coin and start accepted in the same cycle at 5 credits → credits end at 5, state PLAYING, newGame pulse seen.
- Start in READY with 1 credit → credits 0, lives 3, PLAYING. Three playerHit pulses spaced >60 frames apart → lives 2, 1, 0; DYING twice, then GAME_OVER with gameOver pulse; after 180 frames → IDLE.
- playerHit during DYING ignored (lives unchanged). playerHit and levelCleared in the same cycle at lives 2 → lives 1, DYING.
- levelCleared ×4 starting from lives 3 → lives capped at 5.
- resetN pulsed low mid-PLAYING → credits 0, lives 0, IDLE, freezeN 1. With FREE_PLAY_EN: start with 0 credits → PLAYING, credits remain 0.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game flow controller.
// Holds the FSM state encoding exported on gameState, the default
// credit/lives limits and the widths of the exported counters.
package game_ctrl_pkg;

  // Widths of the exported credit and lives counters
  localparam int CREDITS_W = 4;
  localparam int LIVES_W   = 3;

  // Default limits used as parameter defaults by game_flow_ctrl
  localparam int DEF_MAX_CREDITS = 5;
  localparam int DEF_START_LIVES = 3;
  localparam int DEF_MAX_LIVES   = 5;

  // Encoding is visible to the rest of the design through gameState
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_DYING     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

  // Larger of two frame durations, used to size the shared frame counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_debouncer.sv
// Frame-rate button debouncer.
// The raw active-low key is sampled only on startOfFrame. A run of
// DEBOUNCE_FRAMES low samples produces a single one-cycle press pulse;
// the debouncer then stays disarmed until a high sample is seen, so a
// long hold still yields exactly one press.
module frame_debouncer #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic keyN,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic [CNT_W-1:0] low_cnt;
  logic             armed;

  // Count consecutive low frame samples and fire once per hold
  // NOTE: state registers use non-blocking assignments so every flop in the
  // design samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      low_cnt <= '0;
      armed   <= 1'b1;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (startOfFrame) begin
        if (!keyN) begin
          if (low_cnt != CNT_MAX) low_cnt <= low_cnt + 1'b1;
          if (armed && (low_cnt == CNT_MAX - 1'b1)) begin
            press <= 1'b1;
            armed <= 1'b0;
          end
        end else begin
          low_cnt <= '0;
          armed   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: debounces coin/start, owns the credit and
// lives counters and runs IDLE -> READY -> PLAYING -> DYING -> GAME_OVER.
// All outputs are registered.
// Optional feature: define FREE_PLAY_EN for free play (READY entered
// without credits, start consumes nothing, GAME_OVER always returns to READY).
module game_flow_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int MAX_CREDITS     = DEF_MAX_CREDITS,
  parameter int START_LIVES     = DEF_START_LIVES,
  parameter int MAX_LIVES       = DEF_MAX_LIVES,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int DEATH_FRAMES    = 60,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 coinN,
  input  logic                 startN,
  input  logic                 playerHit,
  input  logic                 levelCleared,
  output logic [CREDITS_W-1:0] credits,
  output logic [LIVES_W-1:0]   lives,
  output logic [2:0]           gameState,
  output logic                 gameActive,
  output logic                 freezeN,
  output logic                 newGame,
  output logic                 gameOver
);

`ifdef FREE_PLAY_EN
  localparam bit FREE_PLAY = 1'b1;
`else
  localparam bit FREE_PLAY = 1'b0;
`endif

  localparam int FRAME_MAX = max_int(DEATH_FRAMES, GAMEOVER_FRAMES);
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

  localparam logic [CREDITS_W-1:0] MAX_CREDITS_C = CREDITS_W'(MAX_CREDITS);
  localparam logic [LIVES_W-1:0]   START_LIVES_C = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0]   MAX_LIVES_C   = LIVES_W'(MAX_LIVES);
  localparam logic [FRAME_W-1:0]   DEATH_LAST    = FRAME_W'(DEATH_FRAMES - 1);
  localparam logic [FRAME_W-1:0]   GAMEOVER_LAST = FRAME_W'(GAMEOVER_FRAMES - 1);

  logic                 coin_press;
  logic                 start_press;
  game_state_t          state;
  game_state_t          state_next;
  logic [CREDITS_W-1:0] credits_tmp;
  logic [CREDITS_W-1:0] credits_next;
  logic [LIVES_W-1:0]   lives_next;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 frame_tick;
  logic                 consume;
  logic                 new_game_next;
  logic                 game_over_next;

  frame_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_coin_db (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .keyN         (coinN),
    .press        (coin_press)
  );

  frame_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_start_db (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .keyN         (startN),
    .press        (start_press)
  );

  // Next-state, lives and credit arithmetic for the coming edge
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    lives_next     = lives;
    consume        = 1'b0;
    new_game_next  = 1'b0;
    game_over_next = 1'b0;
    frame_tick     = startOfFrame && (state == ST_DYING || state == ST_GAME_OVER);

    case (state)
      ST_IDLE: begin
        if (FREE_PLAY || credits != '0) state_next = ST_READY;
      end
      ST_READY: begin
        if (start_press) begin
          consume       = !FREE_PLAY;
          lives_next    = START_LIVES_C;
          new_game_next = 1'b1;
          state_next    = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        // A hit takes priority; a simultaneous wave clear is dropped
        if (playerHit) begin
          lives_next = lives - 1'b1;
          if (lives_next == '0) begin
            state_next     = ST_GAME_OVER;
            game_over_next = 1'b1;
          end else begin
            state_next = ST_DYING;
          end
        end else if (levelCleared && lives < MAX_LIVES_C) begin
          lives_next = lives + 1'b1;
        end
      end
      ST_DYING: begin
        if (frame_tick && frame_cnt == DEATH_LAST) state_next = ST_PLAYING;
      end
      ST_GAME_OVER: begin
        if (frame_tick && frame_cnt == GAMEOVER_LAST)
          state_next = (FREE_PLAY || credits != '0) ? ST_READY : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Consume first, then add a coin only if there is room left
    credits_tmp  = credits - CREDITS_W'(consume);
    credits_next = credits_tmp + CREDITS_W'(coin_press && (credits_tmp < MAX_CREDITS_C));
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      credits    <= '0;
      lives      <= '0;
      gameActive <= 1'b0;
      freezeN    <= 1'b1;
      newGame    <= 1'b0;
      gameOver   <= 1'b0;
    end else begin
      state      <= state_next;
      credits    <= credits_next;
      lives      <= lives_next;
      gameActive <= (state_next == ST_PLAYING);
      freezeN    <= !(state_next == ST_DYING || state_next == ST_GAME_OVER);
      newGame    <= new_game_next;
      gameOver   <= game_over_next;
    end
  end

  // Frame counter shared by DYING and GAME_OVER, cleared on every state entry
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
    end else if (state_next != state) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign gameState = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl.
// A cycle-level behavioural model of the game rules runs alongside the DUT
// and every output is compared on each falling edge; directed literal
// expectations at key points pin the model itself.
// Covers the FREE_PLAY_EN build when compiled with that macro defined.
module tb_game_flow_ctrl;

  localparam int MAX_CREDITS     = 5;
  localparam int START_LIVES     = 3;
  localparam int MAX_LIVES       = 5;
  localparam int DEBOUNCE_FRAMES = 3;
  localparam int DEATH_FRAMES    = 60;
  localparam int GAMEOVER_FRAMES = 180;
  localparam int FRAME_LEN       = 4;

`ifdef FREE_PLAY_EN
  localparam bit FREE = 1'b1;
`else
  localparam bit FREE = 1'b0;
`endif

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       coinN;
  logic       startN;
  logic       playerHit;
  logic       levelCleared;
  logic [3:0] credits;
  logic [2:0] lives;
  logic [2:0] gameState;
  logic       gameActive;
  logic       freezeN;
  logic       newGame;
  logic       gameOver;

  int checks   = 0;
  int failures = 0;
  int ng_seen  = 0;
  int go_seen  = 0;

  // Model state
  int m_state, m_credits, m_lives, m_frames;
  int coin_run, start_run;
  bit m_coin_p, m_start_p;
  bit m_active, m_freeze_n, m_new_game, m_game_over;

  game_flow_ctrl #(
    .MAX_CREDITS     (MAX_CREDITS),
    .START_LIVES     (START_LIVES),
    .MAX_LIVES       (MAX_LIVES),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .DEATH_FRAMES    (DEATH_FRAMES),
    .GAMEOVER_FRAMES (GAMEOVER_FRAMES)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .coinN        (coinN),
    .startN       (startN),
    .playerHit    (playerHit),
    .levelCleared (levelCleared),
    .credits      (credits),
    .lives        (lives),
    .gameState    (gameState),
    .gameActive   (gameActive),
    .freezeN      (freezeN),
    .newGame      (newGame),
    .gameOver     (gameOver)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One startOfFrame pulse every FRAME_LEN cycles, driven away from the edge
  initial begin
    int fcnt;
    fcnt = 0;
    startOfFrame = 1'b0;
    forever begin
      @(negedge clk);
      fcnt++;
      startOfFrame = (fcnt % FRAME_LEN == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_credits = 0; m_lives = 0; m_frames = 0;
    coin_run = 0; start_run = 0;
    m_coin_p = 0; m_start_p = 0;
    m_active = 0; m_freeze_n = 1; m_new_game = 0; m_game_over = 0;
  endtask

  // Game rules applied once per clock, using pre-edge inputs and model state
  task automatic model_step();
    int ns, nl, nc, nf;
    bit ng, go, cp, sp;
    ns = m_state; nl = m_lives; nf = m_frames; ng = 0; go = 0;
    case (m_state)
      0: if (FREE || m_credits > 0) ns = 1;
      1: if (m_start_p) begin nl = START_LIVES; ng = 1; ns = 2; end
      2: begin
        if (playerHit) begin
          nl = m_lives - 1;
          if (nl == 0) begin ns = 4; go = 1; end
          else ns = 3;
        end else if (levelCleared && m_lives < MAX_LIVES) begin
          nl = m_lives + 1;
        end
      end
      3: if (startOfFrame) begin
        nf++;
        if (nf == DEATH_FRAMES) ns = 2;
      end
      4: if (startOfFrame) begin
        nf++;
        if (nf == GAMEOVER_FRAMES) ns = (FREE || m_credits > 0) ? 1 : 0;
      end
      default: ns = 0;
    endcase
    nc = m_credits - ((m_state == 1 && m_start_p && !FREE) ? 1 : 0);
    if (m_coin_p && nc < MAX_CREDITS) nc++;
    if (ns != m_state) nf = 0;

    cp = 0; sp = 0;
    if (startOfFrame) begin
      coin_run  = coinN  ? 0 : coin_run + 1;
      start_run = startN ? 0 : start_run + 1;
      cp = (coin_run == DEBOUNCE_FRAMES);
      sp = (start_run == DEBOUNCE_FRAMES);
    end

    m_state = ns; m_lives = nl; m_credits = nc; m_frames = nf;
    m_coin_p = cp; m_start_p = sp;
    m_active    = (ns == 2);
    m_freeze_n  = !(ns == 3 || ns == 4);
    m_new_game  = ng;
    m_game_over = go;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetN);
      if (!resetN) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_state",    gameState,    m_state);
      check("cyc_credits",  credits,      m_credits);
      check("cyc_lives",    lives,        m_lives);
      check("cyc_active",   gameActive,   m_active);
      check("cyc_freezeN",  freezeN,      m_freeze_n);
      check("cyc_newGame",  newGame,      m_new_game);
      check("cyc_gameOver", gameOver,     m_game_over);
      if (newGame === 1'b1)  ng_seen++;
      if (gameOver === 1'b1) go_seen++;
    end
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME_LEN) @(negedge clk);
  endtask

  // Hold the selected buttons low for hold_frames frames, then release
  task automatic press(input bit coin, input bit start, input int hold_frames);
    @(negedge clk);
    if (coin)  coinN  = 1'b0;
    if (start) startN = 1'b0;
    wait_frames(hold_frames);
    coinN  = 1'b1;
    startN = 1'b1;
    wait_frames(2);
  endtask

  task automatic pulse(input bit hit, input bit lvl);
    @(negedge clk);
    playerHit    = hit;
    levelCleared = lvl;
    @(negedge clk);
    playerHit    = 1'b0;
    levelCleared = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    repeat (4) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    resetN = 1'b0; coinN = 1'b1; startN = 1'b1;
    playerHit = 1'b0; levelCleared = 1'b0;
    do_reset();

`ifdef FREE_PLAY_EN
    check("fp_ready_no_credit", gameState, 1);
    check("fp_credits0",        credits,   0);
    press(1'b0, 1'b1, 4);
    check("fp_playing",         gameState, 2);
    check("fp_credits_kept",    credits,   0);
    check("fp_lives_start",     lives,     3);
    press(1'b1, 1'b0, 4);
    check("fp_coin_counts",     credits,   1);
    pulse(1'b1, 1'b0); wait_frames(62);
    pulse(1'b1, 1'b0); wait_frames(62);
    pulse(1'b1, 1'b0);
    check("fp_game_over",       gameState, 4);
    wait_frames(182);
    check("fp_back_to_ready",   gameState, 1);
`else
    check("rst_state",   gameState,  0);
    check("rst_credits", credits,    0);
    check("rst_lives",   lives,      0);
    check("rst_freezeN", freezeN,    1);
    check("rst_active",  gameActive, 0);

    // First coin: 0 -> 1 and IDLE -> READY
    press(1'b1, 1'b0, 4);
    check("coin1_credits", credits,   1);
    check("coin1_ready",   gameState, 1);

    // Long hold still yields a single credit
    press(1'b1, 1'b0, 10);
    check("long_hold_credits", credits, 2);

    // Four more presses (six total) saturate at MAX_CREDITS
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 4);
    check("coin_saturate", credits, 5);

    // Coin and start accepted together at full credits
    press(1'b1, 1'b1, 4);
    check("both_credits",  credits,   5);
    check("both_playing",  gameState, 2);
    check("both_lives",    lives,     3);
    check("both_newgame",  ng_seen,   1);
    check("both_active",   gameActive, 1);

    // Bonus lives capped at MAX_LIVES
    for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
    check("bonus_cap", lives, 5);

    // Hit -> DYING, further hits ignored while dying
    pulse(1'b1, 1'b0);
    check("hit1_lives", lives,     4);
    check("hit1_dying", gameState, 3);
    check("hit1_freeze", freezeN,  0);
    wait_frames(2);
    pulse(1'b1, 1'b1);
    check("dying_ignores_hit", lives, 4);
    wait_frames(62);
    check("dying_exit", gameState, 2);

    pulse(1'b1, 1'b0); wait_frames(62);
    pulse(1'b1, 1'b0); wait_frames(62);
    check("lives_two", lives, 2);

    // Hit and clear together: hit wins
    pulse(1'b1, 1'b1);
    check("hit_wins_lives", lives,     1);
    check("hit_wins_dying", gameState, 3);
    wait_frames(62);

    // Last life
    pulse(1'b1, 1'b0);
    check("last_lives",    lives,     0);
    check("last_gameover", gameState, 4);
    check("gameover_seen", go_seen,   1);
    wait_frames(182);
    check("go_to_ready", gameState, 1);
    check("go_lives0",   lives,     0);

    // New game, then asynchronous reset in the middle of play
    press(1'b0, 1'b1, 4);
    check("game2_credits", credits,   4);
    check("game2_playing", gameState, 2);
    wait_frames(3);
    @(negedge clk);
    #1 resetN = 1'b0;
    #1;
    check("async_rst_state",   gameState, 0);
    check("async_rst_credits", credits,   0);
    check("async_rst_lives",   lives,     0);
    check("async_rst_freezeN", freezeN,   1);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    // Single credit game through to IDLE
    press(1'b1, 1'b0, 4);
    check("g3_credit", credits, 1);
    press(1'b0, 1'b1, 4);
    check("g3_credits0", credits,   0);
    check("g3_lives3",   lives,     3);
    check("g3_playing",  gameState, 2);
    pulse(1'b1, 1'b0); wait_frames(62);
    pulse(1'b1, 1'b0); wait_frames(62);
    pulse(1'b1, 1'b0);
    check("g3_gameover", gameState, 4);
    check("g3_go_seen",  go_seen,   2);
    wait_frames(182);
    check("g3_idle", gameState, 0);
`endif

    wait_frames(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
